// File: rtl/pipelined_multiplier.sv
// Pipelined signed/unsigned multiplier with per-operation high/low half select and tag passthrough.
// All stages shift together on a single advance condition; the last stage holds the selected result.
module pipelined_multiplier #(
    parameter int DATA_LEN       = 32,
    parameter int PIPELINE_STAGE = 2,
    parameter int TAG_LEN        = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_LEN-1:0] a,
    input  logic [DATA_LEN-1:0] b,
    input  logic                in_signed,
    input  logic                in_high,
    input  logic [TAG_LEN-1:0]  in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_LEN-1:0] result,
    output logic [TAG_LEN-1:0]  out_tag
);

    localparam int PROD_LEN = 2 * DATA_LEN;
    localparam int MID_LEN  = (PIPELINE_STAGE > 1) ? PIPELINE_STAGE - 1 : 1;

    function automatic logic [PROD_LEN-1:0] full_product(
        input logic [DATA_LEN-1:0] x,
        input logic [DATA_LEN-1:0] y,
        input logic                sgn
    );
        logic [PROD_LEN-1:0] x_ext;
        logic [PROD_LEN-1:0] y_ext;
        x_ext = {{DATA_LEN{sgn & x[DATA_LEN-1]}}, x};
        y_ext = {{DATA_LEN{sgn & y[DATA_LEN-1]}}, y};
        return x_ext * y_ext;
    endfunction

    logic                advance_s;
    logic [PROD_LEN-1:0] in_prod_s;
    logic                feed_valid_s;
    logic [PROD_LEN-1:0] feed_prod_s;
    logic                feed_high_s;
    logic [TAG_LEN-1:0]  feed_tag_s;

    logic                out_valid_q, out_valid_d;
    logic [DATA_LEN-1:0] result_q,    result_d;
    logic [TAG_LEN-1:0]  out_tag_q,   out_tag_d;

    // Whole pipeline moves whenever the output slot is empty or being drained.
    assign advance_s = !out_valid_q || out_ready;
    assign in_ready  = advance_s;

    // Full-width product of the operands currently presented.
    always_comb begin
        in_prod_s = full_product(a, b, in_signed);
    end

    generate
        if (PIPELINE_STAGE > 1) begin : g_mid
            logic                mid_valid_q [MID_LEN];
            logic                mid_valid_d [MID_LEN];
            logic [PROD_LEN-1:0] mid_prod_q  [MID_LEN];
            logic [PROD_LEN-1:0] mid_prod_d  [MID_LEN];
            logic                mid_high_q  [MID_LEN];
            logic                mid_high_d  [MID_LEN];
            logic [TAG_LEN-1:0]  mid_tag_q   [MID_LEN];
            logic [TAG_LEN-1:0]  mid_tag_d   [MID_LEN];

            // Next-state of the intermediate product stages; payload only moves with a valid op.
            always_comb begin
                mid_valid_d[0] = advance_s ? in_valid : mid_valid_q[0];
                if (advance_s && in_valid) begin
                    mid_prod_d[0] = in_prod_s;
                    mid_high_d[0] = in_high;
                    mid_tag_d[0]  = in_tag;
                end else begin
                    mid_prod_d[0] = mid_prod_q[0];
                    mid_high_d[0] = mid_high_q[0];
                    mid_tag_d[0]  = mid_tag_q[0];
                end
                for (int i = 1; i < MID_LEN; i++) begin
                    mid_valid_d[i] = advance_s ? mid_valid_q[i-1] : mid_valid_q[i];
                    if (advance_s && mid_valid_q[i-1]) begin
                        mid_prod_d[i] = mid_prod_q[i-1];
                        mid_high_d[i] = mid_high_q[i-1];
                        mid_tag_d[i]  = mid_tag_q[i-1];
                    end else begin
                        mid_prod_d[i] = mid_prod_q[i];
                        mid_high_d[i] = mid_high_q[i];
                        mid_tag_d[i]  = mid_tag_q[i];
                    end
                end
            end

            // Intermediate stage registers.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < MID_LEN; i++) begin
                        mid_valid_q[i] <= 1'b0;
                        mid_prod_q[i]  <= {PROD_LEN{1'b0}};
                        mid_high_q[i]  <= 1'b0;
                        mid_tag_q[i]   <= {TAG_LEN{1'b0}};
                    end
                end else begin
                    for (int i = 0; i < MID_LEN; i++) begin
                        mid_valid_q[i] <= mid_valid_d[i];
                        mid_prod_q[i]  <= mid_prod_d[i];
                        mid_high_q[i]  <= mid_high_d[i];
                        mid_tag_q[i]   <= mid_tag_d[i];
                    end
                end
            end

            assign feed_valid_s = mid_valid_q[MID_LEN-1];
            assign feed_prod_s  = mid_prod_q[MID_LEN-1];
            assign feed_high_s  = mid_high_q[MID_LEN-1];
            assign feed_tag_s   = mid_tag_q[MID_LEN-1];
        end else begin : g_direct
            assign feed_valid_s = in_valid;
            assign feed_prod_s  = in_prod_s;
            assign feed_high_s  = in_high;
            assign feed_tag_s   = in_tag;
        end
    endgenerate

    // Output stage: bubbles clear out_valid but leave the last result and tag in place.
    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        out_tag_d   = out_tag_q;
        if (advance_s) begin
            out_valid_d = feed_valid_s;
            if (feed_valid_s) begin
                result_d  = feed_high_s ? feed_prod_s[PROD_LEN-1:DATA_LEN]
                                        : feed_prod_s[DATA_LEN-1:0];
                out_tag_d = feed_tag_s;
            end else begin
                result_d  = result_q;
                out_tag_d = out_tag_q;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            result_q    <= {DATA_LEN{1'b0}};
            out_tag_q   <= {TAG_LEN{1'b0}};
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            out_tag_q   <= out_tag_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_pipelined_multiplier.sv
// Self-checking bench: directed vectors, back-to-back, stall, reset-in-flight on a 32-bit/2-stage
// build, plus randomized handshaking on 8-bit builds with 1 and 4 stages.
module tb_pipelined_multiplier;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    logic        m_in_valid, m_in_ready, m_signed, m_high, m_out_valid, m_out_ready;
    logic [31:0] m_a, m_b, m_result;
    logic [3:0]  m_tag, m_out_tag;

    logic [1:0]       s_in_valid, s_in_ready, s_signed, s_high, s_out_valid, s_out_ready;
    logic [1:0][7:0]  s_a, s_b, s_result;
    logic [1:0][3:0]  s_tag, s_out_tag;

    pipelined_multiplier #(.DATA_LEN(32), .PIPELINE_STAGE(2), .TAG_LEN(4)) dut_main (
        .clk(clk), .reset(reset), .in_valid(m_in_valid), .in_ready(m_in_ready),
        .a(m_a), .b(m_b), .in_signed(m_signed), .in_high(m_high), .in_tag(m_tag),
        .out_valid(m_out_valid), .out_ready(m_out_ready), .result(m_result), .out_tag(m_out_tag));

    pipelined_multiplier #(.DATA_LEN(8), .PIPELINE_STAGE(1), .TAG_LEN(4)) dut_p1 (
        .clk(clk), .reset(reset), .in_valid(s_in_valid[0]), .in_ready(s_in_ready[0]),
        .a(s_a[0]), .b(s_b[0]), .in_signed(s_signed[0]), .in_high(s_high[0]), .in_tag(s_tag[0]),
        .out_valid(s_out_valid[0]), .out_ready(s_out_ready[0]), .result(s_result[0]),
        .out_tag(s_out_tag[0]));

    pipelined_multiplier #(.DATA_LEN(8), .PIPELINE_STAGE(4), .TAG_LEN(4)) dut_p4 (
        .clk(clk), .reset(reset), .in_valid(s_in_valid[1]), .in_ready(s_in_ready[1]),
        .a(s_a[1]), .b(s_b[1]), .in_signed(s_signed[1]), .in_high(s_high[1]), .in_tag(s_tag[1]),
        .out_valid(s_out_valid[1]), .out_ready(s_out_ready[1]), .result(s_result[1]),
        .out_tag(s_out_tag[1]));

    // Reference: extend each operand to 64 bits by arithmetic, multiply, pick the requested half.
    function automatic logic [63:0] ref_result(input logic [63:0] x, input logic [63:0] y,
                                               input int w, input bit sgn, input bit hi);
        logic [63:0] one_w, mask, xe, ye, p;
        one_w = 64'd1 << w;
        mask  = one_w - 64'd1;
        xe    = (sgn && x[w-1]) ? x - one_w : x;
        ye    = (sgn && y[w-1]) ? y - one_w : y;
        p     = xe * ye;
        return hi ? ((p >> w) & mask) : (p & mask);
    endfunction

    task automatic drive_main(input logic v, input logic [31:0] av, input logic [31:0] bv,
                              input logic sv, input logic hv, input logic [3:0] tv);
        m_in_valid = v; m_a = av; m_b = bv; m_signed = sv; m_high = hv; m_tag = tv;
    endtask

    task automatic test_reset();
        drive_main(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 4'd0);
        m_out_ready = 1'b1;
        s_in_valid = 2'b00; s_out_ready = 2'b11; s_a = '0; s_b = '0;
        s_signed = 2'b00; s_high = 2'b00; s_tag = '0;
        reset = 1'b0;
        #1 reset = 1'b1;
        #1;
        n_cmp++; if (m_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", m_out_valid); end
        n_cmp++; if (m_result !== 32'd0) begin n_err++; $display("FAIL reset_result: got %h expected 0", m_result); end
        n_cmp++; if (m_out_tag !== 4'd0) begin n_err++; $display("FAIL reset_out_tag: got %h expected 0", m_out_tag); end
        n_cmp++; if (m_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", m_in_ready); end
        n_cmp++; if (s_out_valid !== 2'b00) begin n_err++; $display("FAIL reset_small_out_valid: got %b expected 00", s_out_valid); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_vectors();
        logic [31:0] va [5];
        logic [31:0] vb [5];
        logic [31:0] ve [5];
        bit          vs [5];
        bit          vh [5];
        va = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vb = '{32'd5,         32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vs = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vh = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        ve = '{32'hFFFF_FFF1, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 32'h0000_0000};
        m_out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            drive_main(1'b1, va[i], vb[i], vs[i], vh[i], 4'(i + 3));
            @(negedge clk);
            n_cmp++; if (m_in_ready !== 1'b1) begin n_err++; $display("FAIL vec%0d_in_ready: got %b expected 1", i, m_in_ready); end
            @(posedge clk); #1;
            drive_main(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 4'd0);
            @(negedge clk);
            n_cmp++; if (m_out_valid !== 1'b0) begin n_err++; $display("FAIL vec%0d_early: got out_valid %b expected 0", i, m_out_valid); end
            @(negedge clk);
            n_cmp++; if (m_out_valid !== 1'b1) begin n_err++; $display("FAIL vec%0d_valid: got %b expected 1", i, m_out_valid); end
            n_cmp++; if (m_result !== ve[i]) begin n_err++; $display("FAIL vec%0d_result: got %h expected %h", i, m_result, ve[i]); end
            n_cmp++; if (m_out_tag !== 4'(i + 3)) begin n_err++; $display("FAIL vec%0d_tag: got %h expected %h", i, m_out_tag, 4'(i + 3)); end
            @(negedge clk);
            n_cmp++; if (m_out_valid !== 1'b0 || m_result !== ve[i]) begin n_err++; $display("FAIL vec%0d_retain: got valid %b result %h expected 0 %h", i, m_out_valid, m_result, ve[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ea [8];
        logic [31:0] eb [8];
        bit          es [8];
        bit          eh [8];
        logic [31:0] exp_r;
        for (int i = 0; i < 8; i++) begin
            ea[i] = $urandom; eb[i] = $urandom;
            es[i] = 1'($urandom_range(0, 1)); eh[i] = 1'($urandom_range(0, 1));
        end
        m_out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (c < 8) drive_main(1'b1, ea[c], eb[c], es[c], eh[c], 4'(c));
            else       drive_main(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 4'd0);
            @(negedge clk);
            n_cmp++; if (m_in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready c=%0d: got %b expected 1", c, m_in_ready); end
            n_cmp++; if (m_out_valid !== (c >= 2 && c < 10)) begin n_err++; $display("FAIL b2b_valid c=%0d: got %b expected %b", c, m_out_valid, (c >= 2 && c < 10)); end
            if (c >= 2 && c < 10) begin
                exp_r = 32'(ref_result({32'd0, ea[c-2]}, {32'd0, eb[c-2]}, 32, es[c-2], eh[c-2]));
                n_cmp++; if (m_out_tag !== 4'(c - 2)) begin n_err++; $display("FAIL b2b_tag c=%0d: got %h expected %h", c, m_out_tag, 4'(c - 2)); end
                n_cmp++; if (m_result !== exp_r) begin n_err++; $display("FAIL b2b_result c=%0d: got %h expected %h", c, m_result, exp_r); end
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] oa [6];
        logic [31:0] ob [6];
        bit          os [6];
        bit          oh [6];
        logic [35:0] exp_q [6];
        logic [31:0] snap_r;
        logic [3:0]  snap_t;
        int          wr = 0;
        int          rd = 0;
        for (int i = 0; i < 6; i++) begin
            oa[i] = $urandom; ob[i] = $urandom;
            os[i] = 1'($urandom_range(0, 1)); oh[i] = 1'($urandom_range(0, 1));
        end
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            m_out_ready = (c >= 7);
            if (wr < 6) drive_main(1'b1, oa[wr], ob[wr], os[wr], oh[wr], 4'(wr + 8));
            else        drive_main(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 4'd0);
            @(negedge clk);
            if (c == 2) begin
                snap_r = m_result; snap_t = m_out_tag;
                n_cmp++; if (m_out_valid !== 1'b1) begin n_err++; $display("FAIL stall_full: got out_valid %b expected 1", m_out_valid); end
            end
            if (c >= 2 && c <= 6) begin
                n_cmp++; if (m_in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready c=%0d: got %b expected 0", c, m_in_ready); end
                n_cmp++; if (m_out_valid !== 1'b1 || m_result !== snap_r || m_out_tag !== snap_t) begin n_err++; $display("FAIL stall_frozen c=%0d: got %b %h %h expected 1 %h %h", c, m_out_valid, m_result, m_out_tag, snap_r, snap_t); end
            end
            if (m_out_valid && m_out_ready) begin
                if (rd >= wr) begin
                    n_cmp++; n_err++; $display("FAIL stall_extra_output: got tag %h expected none", m_out_tag);
                end else begin
                    n_cmp++; if ({m_out_tag, m_result} !== exp_q[rd]) begin n_err++; $display("FAIL stall_output %0d: got %h expected %h", rd, {m_out_tag, m_result}, exp_q[rd]); end
                    rd++;
                end
            end
            if (m_in_valid && m_in_ready) begin
                exp_q[wr] = {4'(wr + 8), 32'(ref_result({32'd0, oa[wr]}, {32'd0, ob[wr]}, 32, os[wr], oh[wr]))};
                wr++;
            end
        end
        n_cmp++; if (rd !== 6) begin n_err++; $display("FAIL stall_delivered: got %0d expected 6", rd); end
    endtask

    task automatic test_random_small();
        logic [11:0] exp_mem [2][256];
        int          wr [2];
        int          rd [2];
        bit          pending [2];
        bit          prev_stall [2];
        logic [7:0]  prev_res [2];
        logic [3:0]  prev_tag [2];
        for (int k = 0; k < 2; k++) begin
            wr[k] = 0; rd[k] = 0; pending[k] = 1'b0; prev_stall[k] = 1'b0;
        end
        for (int c = 0; c < 1000; c++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++) begin
                if (!pending[k] && wr[k] < 200 && $urandom_range(0, 3) != 0) begin
                    pending[k] = 1'b1;
                    s_a[k] = 8'($urandom); s_b[k] = 8'($urandom);
                    s_signed[k] = 1'($urandom_range(0, 1)); s_high[k] = 1'($urandom_range(0, 1));
                    s_tag[k] = 4'(wr[k]);
                end
                s_in_valid[k]  = pending[k];
                s_out_ready[k] = (c >= 800) || ($urandom_range(0, 2) != 0);
            end
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                n_cmp++; if (s_in_ready[k] !== (!s_out_valid[k] || s_out_ready[k])) begin n_err++; $display("FAIL rnd%0d_in_ready c=%0d: got %b expected %b", k, c, s_in_ready[k], (!s_out_valid[k] || s_out_ready[k])); end
                if (prev_stall[k]) begin
                    n_cmp++; if (s_out_valid[k] !== 1'b1 || s_result[k] !== prev_res[k] || s_out_tag[k] !== prev_tag[k]) begin n_err++; $display("FAIL rnd%0d_hold c=%0d: got %b %h %h expected 1 %h %h", k, c, s_out_valid[k], s_result[k], s_out_tag[k], prev_res[k], prev_tag[k]); end
                end
                prev_stall[k] = s_out_valid[k] && !s_out_ready[k];
                prev_res[k]   = s_result[k];
                prev_tag[k]   = s_out_tag[k];
                if (s_out_valid[k] && s_out_ready[k]) begin
                    if (rd[k] >= wr[k]) begin
                        n_cmp++; n_err++; $display("FAIL rnd%0d_extra c=%0d: got tag %h expected none", k, c, s_out_tag[k]);
                    end else begin
                        n_cmp++; if ({s_out_tag[k], s_result[k]} !== exp_mem[k][rd[k]]) begin n_err++; $display("FAIL rnd%0d_output %0d: got %h expected %h", k, rd[k], {s_out_tag[k], s_result[k]}, exp_mem[k][rd[k]]); end
                        rd[k]++;
                    end
                end
                if (s_in_valid[k] && s_in_ready[k]) begin
                    exp_mem[k][wr[k]] = {4'(wr[k]), 8'(ref_result({56'd0, s_a[k]}, {56'd0, s_b[k]}, 8, s_signed[k], s_high[k]))};
                    wr[k]++;
                    pending[k] = 1'b0;
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (wr[k] !== 200 || rd[k] !== 200) begin n_err++; $display("FAIL rnd%0d_count: got sent %0d received %0d expected 200 200", k, wr[k], rd[k]); end
        end
        s_in_valid = 2'b00;
    endtask

    task automatic test_reset_midflight();
        logic [31:0] exp_r;
        m_out_ready = 1'b1;
        @(posedge clk); #1 drive_main(1'b1, 32'h1234_5678, 32'h0000_0003, 1'b0, 1'b0, 4'hA);
        @(posedge clk); #1 drive_main(1'b1, 32'h0000_0007, 32'h0000_0009, 1'b0, 1'b0, 4'hB);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        n_cmp++; if (m_out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_out_valid: got %b expected 0", m_out_valid); end
        n_cmp++; if (m_result !== 32'd0 || m_out_tag !== 4'd0) begin n_err++; $display("FAIL midrst_result: got %h/%h expected 0/0", m_result, m_out_tag); end
        n_cmp++; if (m_in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_in_ready: got %b expected 1", m_in_ready); end
        drive_main(1'b1, 32'hFFFF_FFFE, 32'h0000_0004, 1'b1, 1'b0, 4'h5);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        drive_main(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 4'd0);
        @(negedge clk);
        n_cmp++; if (m_out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_stale: got out_valid %b expected 0", m_out_valid); end
        @(negedge clk);
        exp_r = 32'hFFFF_FFF8;
        n_cmp++; if (m_out_valid !== 1'b1 || m_result !== exp_r || m_out_tag !== 4'h5) begin n_err++; $display("FAIL midrst_first_accept: got %b %h %h expected 1 %h 5", m_out_valid, m_result, m_out_tag, exp_r); end
        @(negedge clk);
        n_cmp++; if (m_out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_drained: got out_valid %b expected 0", m_out_valid); end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_stall();
        test_random_small();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipelined_multiplier.md
PIPELINED_MULTIPLIER -- requirements
Module: pipelined_multiplier

Interface
REQ-001 Parameter DATA_LEN, default 32, operand and result width in bits (>=2).
REQ-002 Parameter PIPELINE_STAGE, default 2, issue-to-output latency in cycles (>=1).
REQ-003 Parameter TAG_LEN, default 4, width of the sideband tag carried alongside each operation (>=1).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  operands and mode presented this cycle.
REQ-007 in_ready  output  1  block accepts an operation this cycle.
REQ-008 a  input  DATA_LEN  multiplicand.
REQ-009 b  input  DATA_LEN  multiplier.
REQ-010 in_signed  input  1  1 = both operands two's-complement; 0 = both unsigned.
REQ-011 in_high  input  1  1 = return upper DATA_LEN bits of the product; 0 = lower DATA_LEN bits.
REQ-012 in_tag  input  TAG_LEN  opaque sideband, returned unchanged with the result.
REQ-013 out_valid  output  1  result and out_tag are valid.
REQ-014 out_ready  input  1  consumer takes the result this cycle.
REQ-015 result  output  DATA_LEN  selected half of the product.
REQ-016 out_tag  output  TAG_LEN  tag of the operation in result.

Function
REQ-017 Transfer on each side occurs only on a cycle with valid && ready both high.
REQ-018 Pipeline has PIPELINE_STAGE register stages, each holding a valid bit, the operation's data (operands or partial/full product), in_high and tag.
REQ-019 advance = !out_valid || out_ready; in_ready SHALL equal advance, combinationally, and never depend on in_valid.
REQ-020 On advance, all stages shift one position; stage 0 loads in_valid (with data) from the input; when advance is low, every stage holds its contents.
REQ-021 Bubbles are not collapsed; a stage holding valid=0 still moves only on advance.
REQ-022 Zero-stall latency: operation accepted at edge N appears with out_valid=1 after edge N+PIPELINE_STAGE-1 (i.e., visible in cycle N+PIPELINE_STAGE); sustained throughput one operation per cycle.
REQ-023 Product computed at 2*DATA_LEN bits: signed mode sign-extends both operands, unsigned mode zero-extends; no overflow or saturation.
REQ-024 result = product[2*DATA_LEN-1:DATA_LEN] when in_high=1, else product[DATA_LEN-1:0]; mode bits are sampled per operation at acceptance.
REQ-025 While out_valid=1 and out_ready=0, result, out_tag and out_valid SHALL remain stable.
REQ-026 Simultaneous output pop and input accept in one cycle SHALL both take effect with no lost or duplicated operation.
REQ-027 in_valid while in_ready=0 is ignored; the source must hold it, and the block SHALL not capture it.
REQ-028 When out_valid=0, result and out_tag retain the last values loaded into the output stage.
REQ-029 Operations leave in acceptance order; the tag is a pure passenger and never alters arithmetic.

Reset
REQ-030 Asserting reset SHALL immediately, without a clock, clear every stage valid bit, out_valid, result and out_tag to 0.
REQ-031 Operations in flight at reset are discarded; in_ready is 1 while reset is held and out_valid is 0.
REQ-032 First acceptance is possible on the first rising edge with reset low.

Verification
REQ-033 DATA_LEN=32, PIPELINE_STAGE=2: signed a=0xFFFFFFFD (-3), b=5, high=0 -> result 0xFFFFFFF1 in cycle 2; same with high=1 -> 0xFFFFFFFF.
REQ-034 Unsigned a=b=0xFFFFFFFF: high=0 -> 0x00000001, high=1 -> 0xFFFFFFFE; same operands signed, high=1 -> 0x00000000.
REQ-035 Back-to-back 8 operations, tags 0..7, out_ready=1 -> 8 consecutive out_valid cycles, tags 0..7 in order, in_ready constantly 1.
REQ-036 out_ready=0 for 5 cycles with pipeline full -> in_ready=0, result/out_tag frozen; release -> all operations delivered once, none lost.
REQ-037 Reset asserted mid-clock with 2 operations in flight -> out_valid and result 0 before next edge; no stale result after deassertion.
REQ-038 PIPELINE_STAGE=1 and 4 builds, DATA_LEN=8, random operands/modes against a reference model with random in_valid/out_ready -> bit-exact, in-order results.
